// File: rtl/onehot_serial_encoder_pkg.sv
// Shared definitions for the one-hot serial encoder: FSM state encoding
// and the index-width helper used by the interface, top and sub-module.
package encoder_pkg;

    // Two-state burst controller: waiting for a vector, or emitting its indices.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Width of a binary index that can address every bit of a w-bit vector.
    function automatic int bin_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/onehot_serial_encoder_if.sv
// Handshake bundle for the one-hot serial encoder: vector input channel
// and binary index output channel. "slave" is the encoder side, "master"
// is the surrounding logic that supplies vectors and consumes indices.
interface onehot_serial_encoder_if
    import encoder_pkg::*;
#(
    parameter int ONE_HOT_WIDTH = 17
);
    localparam int BIN_WIDTH = bin_width(ONE_HOT_WIDTH);

    // Vector channel
    logic                     i_vec_valid;
    logic                     o_vec_ready;
    logic [ONE_HOT_WIDTH-1:0] i_vec;

    // Index channel
    logic                     o_bin_valid;
    logic                     i_bin_ready;
    logic [BIN_WIDTH-1:0]     o_bin;
    logic                     o_last;

    // Status
    logic                     o_onehot;
    logic                     o_empty_err;

    modport slave (
        input  i_vec_valid, i_vec, i_bin_ready,
        output o_vec_ready, o_bin_valid, o_bin, o_last, o_onehot, o_empty_err
    );

    modport master (
        output i_vec_valid, i_vec, i_bin_ready,
        input  o_vec_ready, o_bin_valid, o_bin, o_last, o_onehot, o_empty_err
    );

endinterface

// File: rtl/onehot_serial_encoder_lsb.sv
// Lowest-set-bit priority encoder. Purely combinational: returns the index
// of the lowest set bit (0 for an all-zero input) and flags whether exactly
// one bit is set. Reusable wherever a request vector must be arbitrated LSB-first.
module lsb_prio_encoder
    import encoder_pkg::*;
#(
    parameter int ONE_HOT_WIDTH = 17,
    localparam int BIN_WIDTH    = bin_width(ONE_HOT_WIDTH)
) (
    input  logic [ONE_HOT_WIDTH-1:0] pending,
    output logic [BIN_WIDTH-1:0]     index,
    output logic                     exactly_one
);

    localparam logic [ONE_HOT_WIDTH-1:0] ONE = ONE_HOT_WIDTH'(1);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        index = '0;
        for (int i = ONE_HOT_WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                index = BIN_WIDTH'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit; zero afterwards means it was the only one.
    assign exactly_one = (pending != '0) && ((pending & (pending - ONE)) == '0);

endmodule

// File: rtl/onehot_serial_encoder.sv
// One-hot serial encoder: accepts a request vector and streams the binary
// index of each set bit, lowest first, one per handshake beat. Reports
// whether the vector was strictly one-hot and pulses on all-zero vectors.
// ONE_HOT_WIDTH must be at least 2.
module onehot_serial_encoder
    import encoder_pkg::*;
#(
    parameter int ONE_HOT_WIDTH = 17
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    onehot_serial_encoder_if.slave   bus
);

    localparam int BIN_WIDTH = bin_width(ONE_HOT_WIDTH);
    localparam logic [ONE_HOT_WIDTH-1:0] ONE = ONE_HOT_WIDTH'(1);

    state_e                   state;
    logic [ONE_HOT_WIDTH-1:0] pending;
    logic                     onehot_q;
    logic                     empty_err_q;

    logic [BIN_WIDTH-1:0]     lowest_idx;
    logic                     pending_single;
    logic                     vec_accept;
    logic                     vec_is_onehot;
    logic                     beat_done;

    // Index and "last beat" both come straight from the pending register.
    lsb_prio_encoder #(
        .ONE_HOT_WIDTH (ONE_HOT_WIDTH)
    ) u_lsb_prio_encoder (
        .pending     (pending),
        .index       (lowest_idx),
        .exactly_one (pending_single)
    );

    assign vec_accept    = bus.i_vec_valid && (state == ST_IDLE);
    assign beat_done     = (state == ST_SCAN) && bus.i_bin_ready;
    assign vec_is_onehot = (bus.i_vec != '0) &&
                           ((bus.i_vec & (bus.i_vec - ONE)) == '0);

    // Burst FSM: load a vector in IDLE, retire one lowest bit per beat in SCAN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            pending     <= '0;
            onehot_q    <= 1'b0;
            empty_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every register sees pre-edge values.
            empty_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (vec_accept) begin
                        if (bus.i_vec != '0) begin
                            pending  <= bus.i_vec;
                            onehot_q <= vec_is_onehot;
                            state    <= ST_SCAN;
                        end else begin
                            empty_err_q <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (beat_done) begin
                        // Clearing the lowest set bit is exactly the bit just emitted.
                        pending <= pending & (pending - ONE);
                        if (pending_single) begin
                            onehot_q <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are functions of registers only; no input-to-output path.
    assign bus.o_vec_ready = (state == ST_IDLE);
    assign bus.o_bin_valid = (state == ST_SCAN);
    assign bus.o_bin       = lowest_idx;
    assign bus.o_last      = pending_single;
    assign bus.o_onehot    = onehot_q;
    assign bus.o_empty_err = empty_err_q;

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Self-checking bench for onehot_serial_encoder: a table of vectors
// (directed sweep, corner patterns, random) replayed against a queue-based
// reference, plus hand-written backpressure and mid-burst reset sequences.
module tb_onehot_serial_encoder;

    localparam int W   = 17;
    localparam int BW  = $clog2(W);
    localparam int MAX_CYCLES = 20 * W;
    localparam int N_RAND = 40;

    typedef struct {
        logic [W-1:0] vec;
        bit           rand_ready;
        int           exp_first;
        int           exp_count;
        bit           exp_onehot;
    } vec_rec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    onehot_serial_encoder_if #(.ONE_HOT_WIDTH(W)) bus ();

    onehot_serial_encoder #(
        .ONE_HOT_WIDTH (W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the indices of all set bits, ascending.
    function automatic void model_indices(input logic [W-1:0] v, output int q[$]);
        q = {};
        for (int i = 0; i < W; i++) begin
            if (v[i]) q.push_back(i);
        end
    endfunction

    function automatic vec_rec_t make_rec(input logic [W-1:0] v, input bit rr);
        vec_rec_t r;
        int q[$];
        model_indices(v, q);
        r.vec        = v;
        r.rand_ready = rr;
        r.exp_count  = q.size();
        r.exp_first  = (q.size() > 0) ? q[0] : 0;
        r.exp_onehot = (q.size() == 1);
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_valid"},  32'(bus.o_bin_valid), 0);
        check({tag, "_ready"},  32'(bus.o_vec_ready), 1);
        check({tag, "_bin"},    32'(bus.o_bin),       0);
        check({tag, "_last"},   32'(bus.o_last),      0);
        check({tag, "_onehot"}, 32'(bus.o_onehot),    0);
    endtask

    // Present one vector and drain its beats, comparing each against the model.
    task automatic run_burst(input vec_rec_t r);
        int q[$];
        int beats;
        int cyc;
        bit rdy;
        model_indices(r.vec, q);
        @(negedge clk);
        check("accept_ready", 32'(bus.o_vec_ready), 1);
        bus.i_vec_valid = 1'b1;
        bus.i_vec       = r.vec;
        @(negedge clk);
        bus.i_vec_valid = 1'b0;
        bus.i_vec       = W'($urandom);
        if (r.vec == '0) begin
            check("empty_err_on",  32'(bus.o_empty_err), 1);
            check("empty_valid",   32'(bus.o_bin_valid), 0);
            check("empty_ready",   32'(bus.o_vec_ready), 1);
            @(negedge clk);
            check("empty_err_off", 32'(bus.o_empty_err), 0);
            check("empty_valid2",  32'(bus.o_bin_valid), 0);
            return;
        end
        check("first_valid", 32'(bus.o_bin_valid), 1);
        check("first_bin",   32'(bus.o_bin),       32'(r.exp_first));
        beats = 0;
        cyc   = 0;
        while (q.size() > 0 && cyc < MAX_CYCLES) begin
            if (bus.o_bin_valid !== 1'b1) begin
                check("beat_valid", 32'(bus.o_bin_valid), 1);
                break;
            end
            check("beat_bin",    32'(bus.o_bin),       32'(q[0]));
            check("beat_last",   32'(bus.o_last),      32'(q.size() == 1));
            check("beat_onehot", 32'(bus.o_onehot),    32'(r.exp_onehot));
            check("beat_vready", 32'(bus.o_vec_ready), 0);
            rdy = r.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_bin_ready = rdy;
            @(negedge clk);
            if (rdy) begin
                void'(q.pop_front());
                beats++;
            end
            cyc++;
        end
        bus.i_bin_ready = 1'b0;
        check("beat_count", 32'(beats), 32'(r.exp_count));
        check_idle("post_burst");
    endtask

    vec_rec_t tbl[$];

    initial begin
        errors = 0;
        checks = 0;
        bus.i_vec_valid = 1'b0;
        bus.i_vec       = '0;
        bus.i_bin_ready = 1'b0;

        // Async reset with no clock edge involved.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_idle("reset");
        check("reset_empty_err", 32'(bus.o_empty_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table: single-bit sweep, multi-bit corners, empty, then random.
        for (int i = 0; i < W; i++) tbl.push_back(make_rec(W'(1) << i, 1'b0));
        tbl.push_back(make_rec(17'h10005, 1'b0));
        tbl.push_back(make_rec(17'h00000, 1'b0));
        tbl.push_back(make_rec(17'h1FFFF, 1'b0));
        tbl.push_back(make_rec(17'h1FFFF, 1'b1));
        tbl.push_back(make_rec(17'h10000, 1'b1));
        for (int i = 0; i < N_RAND; i++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            if (i % 5 == 0) v = v & W'($urandom) & W'($urandom);
            if (i % 11 == 0) v = '0;
            tbl.push_back(make_rec(v, 1'b1));
        end
        foreach (tbl[k]) run_burst(tbl[k]);

        // Backpressure: 0x12 held for three cycles, then drained.
        @(negedge clk);
        bus.i_vec_valid = 1'b1;
        bus.i_vec       = 17'h00012;
        @(negedge clk);
        bus.i_vec_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("bp_valid", 32'(bus.o_bin_valid), 1);
            check("bp_bin",   32'(bus.o_bin),       1);
            check("bp_last",  32'(bus.o_last),      0);
            @(negedge clk);
        end
        bus.i_bin_ready = 1'b1;
        check("bp_beat1_bin", 32'(bus.o_bin),  1);
        check("bp_beat1_last", 32'(bus.o_last), 0);
        @(negedge clk);
        check("bp_beat2_valid", 32'(bus.o_bin_valid), 1);
        check("bp_beat2_bin",   32'(bus.o_bin),       4);
        check("bp_beat2_last",  32'(bus.o_last),      1);
        @(negedge clk);
        bus.i_bin_ready = 1'b0;
        check_idle("bp_done");

        // Mid-burst reset: all-ones, one beat taken, reset between edges.
        @(negedge clk);
        bus.i_vec_valid = 1'b1;
        bus.i_vec       = 17'h1FFFF;
        @(negedge clk);
        bus.i_vec_valid = 1'b0;
        check("mr_beat0_valid", 32'(bus.o_bin_valid), 1);
        check("mr_beat0_bin",   32'(bus.o_bin),       0);
        bus.i_bin_ready = 1'b1;
        @(negedge clk);
        bus.i_bin_ready = 1'b0;
        check("mr_beat1_bin", 32'(bus.o_bin), 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("mr_reset");
        repeat (2) begin
            @(negedge clk);
            check("mr_in_reset_valid", 32'(bus.o_bin_valid), 0);
        end
        rst_n = 1'b1;
        bus.i_bin_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mr_after_valid", 32'(bus.o_bin_valid), 0);
        end
        bus.i_bin_ready = 1'b0;
        run_burst(make_rec(17'h00100, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
